// File: rtl/conv_out_writer.sv
// Output-side sink for the convolution pixel stream: packs PACK pixels per SRAM word,
// tracks row/column, flushes a masked partial word at frame end and flags protocol errors.
module conv_out_writer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PACK      = 4,
  parameter int unsigned OUT_W     = 28,
  parameter int unsigned OUT_H     = 28,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  localparam int unsigned RW = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int unsigned CW = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int unsigned LW = $clog2(PACK)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [PACK*DATA_W-1:0] wr_data,
  output logic [PACK-1:0]        wr_mask,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err,
  output logic [RW-1:0]          row,
  output logic [CW-1:0]          col
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [PACK*DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [PACK*DATA_W-1:0] wr_data_q, wr_data_d;
  logic [PACK-1:0]        wr_mask_q, wr_mask_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [PACK*DATA_W-1:0] buf_fill;
  logic [PACK-1:0]        mask_part;
  logic                   accept, last_pix;

  assign accept   = (state_q == S_RUN) && in_valid;
  assign last_pix = accept && (row_q == RW'(OUT_H - 1)) && (col_q == CW'(OUT_W - 1));

  always_comb begin
    buf_fill  = buf_q;
    mask_part = '0;
    for (int unsigned k = 0; k < PACK; k++) begin
      if (LW'(k) == lane_q) buf_fill[k*DATA_W +: DATA_W] = in_data;
      mask_part[k] = (LW'(k) <= lane_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    buf_d     = buf_q;
    addr_d    = addr_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mask_d = '0;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          lane_d  = '0;
          buf_d   = '0;
          addr_d  = ADDR_W'(BASE_ADDR);
          row_d   = '0;
          col_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          lane_d = lane_q + LW'(1);
          if (col_q == CW'(OUT_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          // Full words and the final partial word both leave through the same
          // registered write port; the partial one is emitted during FLUSH.
          if (lane_q == LW'(PACK - 1) || last_pix) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = buf_fill;
            wr_mask_d = mask_part;
            addr_d    = addr_q + ADDR_W'(1);
            buf_d     = '0;
          end else begin
            buf_d = buf_fill;
          end
          if (last_pix) begin
            state_d = S_FLUSH;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (in_valid && state_q != S_RUN) err_d = 1'b1;

    busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      buf_q     <= '0;
      addr_q    <= ADDR_W'(BASE_ADDR);
      row_q     <= '0;
      col_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= ADDR_W'(BASE_ADDR);
      wr_data_q <= '0;
      wr_mask_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      buf_q     <= buf_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_mask    = wr_mask_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err        = err_q;
  assign row        = row_q;
  assign col        = col_q;

endmodule

// File: tb/tb_conv_out_writer.sv
// Randomized bench for conv_out_writer: three instances (default, 3x3 frame, wrapping base
// address) checked against a word-packing model built from the pixel list.
module tb_conv_out_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_a, vld_a, wr_en_a, busy_a, done_a, err_a;
  logic [7:0] din_a;
  logic [9:0] wr_addr_a;
  logic [31:0] wr_data_a;
  logic [3:0] wr_mask_a;
  logic [4:0] row_a, col_a;

  logic       start_b, vld_b, wr_en_b, busy_b, done_b, err_b;
  logic [7:0] din_b;
  logic [9:0] wr_addr_b;
  logic [31:0] wr_data_b;
  logic [3:0] wr_mask_b;
  logic [1:0] row_b, col_b;

  logic       start_c, vld_c, wr_en_c, busy_c, done_c, err_c;
  logic [7:0] din_c;
  logic [9:0] wr_addr_c;
  logic [31:0] wr_data_c;
  logic [3:0] wr_mask_c;
  logic [4:0] row_c, col_c;

  conv_out_writer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(vld_a), .in_data(din_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_mask(wr_mask_a),
    .busy(busy_a), .frame_done(done_a), .err(err_a), .row(row_a), .col(col_a));

  conv_out_writer #(.OUT_W(3), .OUT_H(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(vld_b), .in_data(din_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_mask(wr_mask_b),
    .busy(busy_b), .frame_done(done_b), .err(err_b), .row(row_b), .col(col_b));

  conv_out_writer #(.ADDR_W(10), .BASE_ADDR(1020)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .in_valid(vld_c), .in_data(din_c),
    .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .wr_mask(wr_mask_c),
    .busy(busy_c), .frame_done(done_c), .err(err_c), .row(row_c), .col(col_c));

  logic [9:0]  wa_addr[$], wb_addr[$], wc_addr[$], ex_addr[$];
  logic [31:0] wa_data[$], wb_data[$], wc_data[$], ex_data[$];
  logic [3:0]  wa_mask[$], wb_mask[$], wc_mask[$], ex_mask[$];
  int          wb_cyc[$], fda[$], fdb[$], fdc[$];
  int          pix[$];
  int          n_vec = 0, n_err = 0;
  int          last_drv, snap_row, snap_col;

  always @(negedge clk) begin
    if (wr_en_a) begin wa_addr.push_back(wr_addr_a); wa_data.push_back(wr_data_a); wa_mask.push_back(wr_mask_a); end
    if (wr_en_b) begin wb_addr.push_back(wr_addr_b); wb_data.push_back(wr_data_b); wb_mask.push_back(wr_mask_b); wb_cyc.push_back(cyc); end
    if (wr_en_c) begin wc_addr.push_back(wr_addr_c); wc_data.push_back(wr_data_c); wc_mask.push_back(wr_mask_c); end
    if (done_a) fda.push_back(cyc);
    if (done_b) fdb.push_back(cyc);
    if (done_c) fdc.push_back(cyc);
  end

  // Reference: pixel i lands in word i/4, lane i%4; a short last word carries only its filled lanes.
  function automatic void build_expected(int npix, int base, int aw);
    logic [31:0] d;
    logic [3:0]  m;
    ex_addr.delete(); ex_data.delete(); ex_mask.delete();
    for (int w = 0; w * 4 < npix; w++) begin
      d = '0; m = '0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < npix) begin
          d = d | (32'(pix[w*4+k] & 255) << (8 * k));
          m = m | 4'(1 << k);
        end
      ex_addr.push_back(10'((base + w) % (1 << aw)));
      ex_data.push_back(d);
      ex_mask.push_back(m);
    end
  endfunction

  task automatic clear_mon();
    wa_addr.delete(); wa_data.delete(); wa_mask.delete();
    wb_addr.delete(); wb_data.delete(); wb_mask.delete(); wb_cyc.delete();
    wc_addr.delete(); wc_data.delete(); wc_mask.delete();
    fda.delete(); fdb.delete(); fdc.delete();
  endtask

  task automatic set_in(int sel, logic v, logic [7:0] d);
    case (sel)
      0: begin vld_a = v; din_a = d; end
      1: begin vld_b = v; din_b = d; end
      default: begin vld_c = v; din_c = d; end
    endcase
  endtask

  task automatic pulse_start(int sel);
    case (sel)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic drive(int sel, int gapmax);
    for (int i = 0; i < pix.size(); i++) begin
      repeat ($urandom_range(gapmax, 0)) begin @(posedge clk); #1; end
      if (i == pix.size() - 1) begin
        snap_row = (sel == 1) ? int'(row_b) : (sel == 0) ? int'(row_a) : int'(row_c);
        snap_col = (sel == 1) ? int'(col_b) : (sel == 0) ? int'(col_a) : int'(col_c);
      end
      set_in(sel, 1'b1, 8'(pix[i]));
      last_drv = cyc;
      @(posedge clk); #1;
      set_in(sel, 1'b0, 8'h00);
    end
  endtask

  task automatic wait_done(int sel);
    for (int k = 0; k < 20; k++) begin
      if ((sel == 0 && fda.size() > 0) || (sel == 1 && fdb.size() > 0) || (sel == 2 && fdc.size() > 0)) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic fill_pix(int n, bit idx_data);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(idx_data ? (i % 256) : int'($urandom_range(255, 0)));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 0; start_b = 0; start_c = 0;
    set_in(0, 1'b0, 8'h00); set_in(1, 1'b0, 8'h00); set_in(2, 1'b0, 8'h00);
    repeat (3) @(posedge clk); #1;
    n_vec++; if ({wr_en_a, busy_a, done_a, err_a} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b exp 0000", {wr_en_a, busy_a, done_a, err_a}); end
    n_vec++; if (wr_addr_a !== 10'd0 || wr_data_a !== 32'd0 || wr_mask_a !== 4'd0) begin n_err++; $display("FAIL reset_write got %0h/%0h/%0h exp 0/0/0", wr_addr_a, wr_data_a, wr_mask_a); end
    n_vec++; if (row_a !== 5'd0 || col_a !== 5'd0) begin n_err++; $display("FAIL reset_pos got %0d/%0d exp 0/0", row_a, col_a); end
    n_vec++; if (wr_addr_c !== 10'd1020) begin n_err++; $display("FAIL reset_base got %0d exp 1020", wr_addr_c); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame(int gapmax, string tag);
    clear_mon();
    fill_pix(784, 1'b1);
    pulse_start(0);
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL %s_busy_rise got %b exp 1", tag, busy_a); end
    drive(0, gapmax);
    wait_done(0);
    build_expected(784, 0, 10);
    n_vec++; if (wa_addr.size() != ex_addr.size()) begin n_err++; $display("FAIL %s_count got %0d exp %0d", tag, wa_addr.size(), ex_addr.size()); end
    for (int i = 0; i < ex_addr.size() && i < wa_addr.size(); i++) begin
      n_vec++;
      if (wa_addr[i] !== ex_addr[i] || wa_data[i] !== ex_data[i] || wa_mask[i] !== ex_mask[i]) begin
        n_err++; $display("FAIL %s_word%0d got %0h/%0h/%0h exp %0h/%0h/%0h", tag, i, wa_addr[i], wa_data[i], wa_mask[i], ex_addr[i], ex_data[i], ex_mask[i]);
      end
    end
    n_vec++; if (fda.size() != 1 || (fda.size() == 1 && fda[0] != last_drv + 2)) begin n_err++; $display("FAIL %s_done got n=%0d cyc=%0d exp n=1 cyc=%0d", tag, fda.size(), (fda.size() > 0) ? fda[0] : -1, last_drv + 2); end
    n_vec++; if (err_a !== 1'b0 || busy_a !== 1'b0) begin n_err++; $display("FAIL %s_end_flags got err=%b busy=%b exp 0/0", tag, err_a, busy_a); end
    if (gapmax > 0) begin
      n_vec++; if (snap_row != 27 || snap_col != 27) begin n_err++; $display("FAIL %s_rowcol got %0d/%0d exp 27/27", tag, snap_row, snap_col); end
    end
  endtask

  task automatic test_small_frame();
    for (int f = 0; f < 2; f++) begin
      clear_mon();
      pix.delete();
      for (int i = 0; i < 9; i++) pix.push_back((f == 0) ? i + 1 : int'($urandom_range(255, 0)));
      pulse_start(1);
      drive(1, f);
      wait_done(1);
      build_expected(9, 0, 10);
      n_vec++; if (wb_addr.size() != 3) begin n_err++; $display("FAIL small%0d_count got %0d exp 3", f, wb_addr.size()); end
      for (int i = 0; i < ex_addr.size() && i < wb_addr.size(); i++) begin
        n_vec++;
        if (wb_addr[i] !== ex_addr[i] || wb_data[i] !== ex_data[i] || wb_mask[i] !== ex_mask[i]) begin
          n_err++; $display("FAIL small%0d_word%0d got %0h/%0h/%0h exp %0h/%0h/%0h", f, i, wb_addr[i], wb_data[i], wb_mask[i], ex_addr[i], ex_data[i], ex_mask[i]);
        end
      end
      n_vec++; if (wb_cyc.size() != 3 || (wb_cyc.size() == 3 && wb_cyc[2] != last_drv + 1)) begin n_err++; $display("FAIL small%0d_flush_cyc got %0d exp %0d", f, (wb_cyc.size() == 3) ? wb_cyc[2] : -1, last_drv + 1); end
      n_vec++; if (fdb.size() != 1 || (fdb.size() == 1 && fdb[0] != last_drv + 2)) begin n_err++; $display("FAIL small%0d_done got %0d exp %0d", f, (fdb.size() > 0) ? fdb[0] : -1, last_drv + 2); end
    end
  endtask

  task automatic test_err_idle();
    clear_mon();
    set_in(0, 1'b1, 8'($urandom_range(255, 0)));
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'h00);
    @(posedge clk); #1;
    n_vec++; if (err_a !== 1'b1 || wa_addr.size() != 0) begin n_err++; $display("FAIL err_idle got err=%b writes=%0d exp 1/0", err_a, wa_addr.size()); end
    pulse_start(0);
    n_vec++; if (err_a !== 1'b0) begin n_err++; $display("FAIL err_clear got %b exp 0", err_a); end
    fill_pix(784, 1'b0);
    drive(0, 1);
    wait_done(0);
    build_expected(784, 0, 10);
    n_vec++; if (wa_addr.size() != ex_addr.size()) begin n_err++; $display("FAIL err_frame_count got %0d exp %0d", wa_addr.size(), ex_addr.size()); end
    for (int i = 0; i < ex_addr.size() && i < wa_addr.size(); i++) begin
      n_vec++;
      if (wa_addr[i] !== ex_addr[i] || wa_data[i] !== ex_data[i] || wa_mask[i] !== ex_mask[i]) begin
        n_err++; $display("FAIL err_frame_word%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, wa_addr[i], wa_data[i], wa_mask[i], ex_addr[i], ex_data[i], ex_mask[i]);
      end
    end
    n_vec++; if (fda.size() != 1 || err_a !== 1'b0) begin n_err++; $display("FAIL err_frame_done got n=%0d err=%b exp 1/0", fda.size(), err_a); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    fill_pix(10, 1'b0);
    pulse_start(0);
    drive(0, 0);
    n_vec++; if (wa_addr.size() != 2) begin n_err++; $display("FAIL midrst_pre_writes got %0d exp 2", wa_addr.size()); end
    rst_n = 1'b0;
    #2;
    n_vec++; if ({wr_en_a, busy_a, done_a, err_a} !== 4'b0000 || wr_addr_a !== 10'd0 || wr_data_a !== 32'd0 || wr_mask_a !== 4'd0 || row_a !== 5'd0 || col_a !== 5'd0) begin
      n_err++; $display("FAIL midrst_outputs got en=%b busy=%b addr=%0h data=%0h mask=%0h row=%0d col=%0d exp all 0", wr_en_a, busy_a, wr_addr_a, wr_data_a, wr_mask_a, row_a, col_a);
    end
    clear_mon();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    n_vec++; if (wa_addr.size() != 0) begin n_err++; $display("FAIL midrst_partial got %0d writes exp 0", wa_addr.size()); end
    fill_pix(784, 1'b0);
    pulse_start(0);
    drive(0, 1);
    wait_done(0);
    build_expected(784, 0, 10);
    n_vec++; if (wa_addr.size() != ex_addr.size()) begin n_err++; $display("FAIL midrst_count got %0d exp %0d", wa_addr.size(), ex_addr.size()); end
    for (int i = 0; i < ex_addr.size() && i < wa_addr.size(); i++) begin
      n_vec++;
      if (wa_addr[i] !== ex_addr[i] || wa_data[i] !== ex_data[i] || wa_mask[i] !== ex_mask[i]) begin
        n_err++; $display("FAIL midrst_word%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, wa_addr[i], wa_data[i], wa_mask[i], ex_addr[i], ex_data[i], ex_mask[i]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    clear_mon();
    fill_pix(24, 1'b0);
    pulse_start(2);
    drive(2, 0);
    repeat (3) @(posedge clk); #1;
    build_expected(24, 1020, 10);
    n_vec++; if (wc_addr.size() != 6 || fdc.size() != 0) begin n_err++; $display("FAIL wrap_count got %0d writes %0d dones exp 6/0", wc_addr.size(), fdc.size()); end
    for (int i = 0; i < ex_addr.size() && i < wc_addr.size(); i++) begin
      n_vec++;
      if (wc_addr[i] !== ex_addr[i] || wc_data[i] !== ex_data[i] || wc_mask[i] !== ex_mask[i]) begin
        n_err++; $display("FAIL wrap_word%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, wc_addr[i], wc_data[i], wc_mask[i], ex_addr[i], ex_data[i], ex_mask[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame(0, "contig");
    test_small_frame();
    test_full_frame(3, "gaps");
    test_err_idle();
    test_reset_mid();
    test_addr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_out_writer.md
# conv_out_writer

Output-side sink for `conv_module`: consumes the `out_valid` / `out_data` pixel stream of one convolution frame and packs `PACK` pixels per word into the output feature-map SRAM write port. It tracks row/column position and flushes a final partial word with a lane mask. It flags frame completion and any stream protocol error. It sits between `conv_module` and the output buffer and is the receiving end of the conv output stream.

## Interface
- `DATA_W`, 8, width of one output pixel
- `PACK`, 4, pixels per SRAM word (power of two, ≥2)
- `OUT_W`, 28, output feature-map width in pixels
- `OUT_H`, 28, output feature-map height in pixels
- `ADDR_W`, 10, SRAM word address width
- `BASE_ADDR`, 0, word address of the first packed word
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse: arm for a new frame
- `in_valid`  in  1  pixel valid from `conv_module` (its `out_valid`); no backpressure
- `in_data`  in  DATA_W  pixel value, sampled when `in_valid`=1
- `wr_en`  out  1  SRAM write strobe
- `wr_addr`  out  ADDR_W  SRAM word address
- `wr_data`  out  PACK*DATA_W  packed word; lane k at bits [k*DATA_W +: DATA_W]
- `wr_mask`  out  PACK  per-lane write enable
- `busy`  out  1  high from the cycle after `start` until `frame_done`
- `frame_done`  out  1  one-cycle pulse when the last word of the frame is written
- `err`  out  1  sticky: `in_valid` while not RUN; cleared only by `start`
- `row`  out  clog2(OUT_H)  row of the next expected pixel
- `col`  out  clog2(OUT_W)  column of the next expected pixel

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> FLUSH when the pixel completing the frame (`OUT_W*OUT_H`-th) is accepted.
  - FLUSH -> DONE after one cycle.
  - DONE -> IDLE after one cycle.
  - `start` in any non-IDLE state is ignored.
- On `start`:
  - pixel count, lane index, `row`, `col` cleared to 0
  - word address set to `BASE_ADDR`
  - `err` cleared
- RUN, each `in_valid`=1 cycle:
  - `in_data` stored into lane `lane_idx`; `lane_idx` increments modulo PACK.
  - `col` increments and wraps to 0 at `OUT_W-1`; on wrap `row` increments.
- When lane `PACK-1` is filled in RUN:
  - a full word is written: `wr_mask`=all ones
  - word address increments by 1 after the write
- In FLUSH, a write is issued only if the frame ends mid-word:
  - `wr_mask` has ones in lanes 0..`lane_idx-1`
  - unfilled lanes of `wr_data` are zero
  - if the frame ended exactly on a word boundary, FLUSH issues no write
- `in_valid` in IDLE, FLUSH or DONE: pixel dropped, `err` set.
- Address arithmetic is modulo 2^ADDR_W (wrap-around, no error).
- Reset mid-frame: all state returns to reset values immediately; the partial word is discarded and no write is issued.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0, `wr_mask`=0, `busy`=0, `frame_done`=0, `err`=0, `row`=0, `col`=0; state IDLE.
- All outputs are registered.
- `busy` rises the cycle after `start`.
- Write latency: `wr_en` is high exactly one cycle, in the cycle after the clock edge that sampled the lane `PACK-1` pixel. `wr_addr`, `wr_data` and `wr_mask` are valid in that same cycle.
- Back-to-back pixels produce one write every PACK cycles and sustain full rate with no stalls.
- Flush write: `wr_en` is high in the cycle the FSM is in FLUSH.
- `frame_done` is high in the DONE cycle, i.e. 2 cycles after the last pixel edge. `busy` falls in that same cycle.
- `row`/`col` update in the cycle after the pixel is sampled.

## Test plan
- Defaults, `start`, then 784 contiguous pixels with value = index mod 256:
  - 196 writes, addresses 0..195
  - word 0 data = 0x03020100, mask 0xF
  - no flush write; `frame_done` 2 cycles after the last pixel; `err`=0
- OUT_W=3, OUT_H=3, 9 pixels 1..9:
  - words 0x04030201 @0 and 0x08070605 @1
  - flush 0x00000009 @2 with mask 0x1
  - `frame_done` one cycle after the flush write
- Defaults, pixels with random 0–3 idle-cycle gaps:
  - same addresses and data as scenario 1
  - `row`/`col` reach 27/27 before the last pixel
- `in_valid` pulsed in IDLE before `start`:
  - `err`=1, no write
  - next `start` clears `err`; the frame completes normally
- Reset asserted after 10 pixels:
  - all outputs at reset values, no partial write
  - new `start` + full frame writes from `BASE_ADDR` again
- BASE_ADDR=1020, ADDR_W=10, 24 pixels: writes at 1020, 1021, 1022, 1023, 0, 1.
